// File: rtl/sha_round_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha_round_engine_pkg
//  Purpose  : Shared SHA-256 definitions for the round engine: word size,
//             initial hash value, engine state encodings and the SHA-256
//             compression helper functions (SIG0, SIG1, CH, MAJ).
//  Revision : 1.0  initial release
// ============================================================================
package sha_round_engine_pkg;

    localparam int WORD_S = 32;
    localparam int H_SIZE = 8 * WORD_S;

    localparam logic [H_SIZE-1:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Engine state encodings
    localparam logic [1:0] SRE_IDLE  = 2'd0;
    localparam logic [1:0] SRE_RUN   = 2'd1;
    localparam logic [1:0] SRE_FINAL = 2'd2;

    function automatic logic [WORD_S-1:0] rotr(input logic [WORD_S-1:0] x, input int n);
        return (x >> n) | (x << (WORD_S - n));
    endfunction

    function automatic logic [WORD_S-1:0] big_sig0(input logic [WORD_S-1:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_S-1:0] big_sig1(input logic [WORD_S-1:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_S-1:0] ch(input logic [WORD_S-1:0] x,
                                              input logic [WORD_S-1:0] y,
                                              input logic [WORD_S-1:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [WORD_S-1:0] maj(input logic [WORD_S-1:0] x,
                                               input logic [WORD_S-1:0] y,
                                               input logic [WORD_S-1:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha_round_engine_k_rom.sv
`default_nettype none
// ============================================================================
//  Module   : sha_k_rom
//  Purpose  : Combinational SHA-256 round-constant table, K[i] for i=0..63.
//  Ports    : i_idx [5:0]  round index
//             o_k   [31:0] round constant K[i_idx]
//  Revision : 1.0  initial release
// ============================================================================
module sha_k_rom (
    input  logic [5:0]  i_idx,
    output logic [31:0] o_k
);

    always_comb begin
        o_k = 32'h0;
        case (i_idx)
            6'd0 : o_k = 32'h428a2f98;  6'd1 : o_k = 32'h71374491;
            6'd2 : o_k = 32'hb5c0fbcf;  6'd3 : o_k = 32'he9b5dba5;
            6'd4 : o_k = 32'h3956c25b;  6'd5 : o_k = 32'h59f111f1;
            6'd6 : o_k = 32'h923f82a4;  6'd7 : o_k = 32'hab1c5ed5;
            6'd8 : o_k = 32'hd807aa98;  6'd9 : o_k = 32'h12835b01;
            6'd10: o_k = 32'h243185be;  6'd11: o_k = 32'h550c7dc3;
            6'd12: o_k = 32'h72be5d74;  6'd13: o_k = 32'h80deb1fe;
            6'd14: o_k = 32'h9bdc06a7;  6'd15: o_k = 32'hc19bf174;
            6'd16: o_k = 32'he49b69c1;  6'd17: o_k = 32'hefbe4786;
            6'd18: o_k = 32'h0fc19dc6;  6'd19: o_k = 32'h240ca1cc;
            6'd20: o_k = 32'h2de92c6f;  6'd21: o_k = 32'h4a7484aa;
            6'd22: o_k = 32'h5cb0a9dc;  6'd23: o_k = 32'h76f988da;
            6'd24: o_k = 32'h983e5152;  6'd25: o_k = 32'ha831c66d;
            6'd26: o_k = 32'hb00327c8;  6'd27: o_k = 32'hbf597fc7;
            6'd28: o_k = 32'hc6e00bf3;  6'd29: o_k = 32'hd5a79147;
            6'd30: o_k = 32'h06ca6351;  6'd31: o_k = 32'h14292967;
            6'd32: o_k = 32'h27b70a85;  6'd33: o_k = 32'h2e1b2138;
            6'd34: o_k = 32'h4d2c6dfc;  6'd35: o_k = 32'h53380d13;
            6'd36: o_k = 32'h650a7354;  6'd37: o_k = 32'h766a0abb;
            6'd38: o_k = 32'h81c2c92e;  6'd39: o_k = 32'h92722c85;
            6'd40: o_k = 32'ha2bfe8a1;  6'd41: o_k = 32'ha81a664b;
            6'd42: o_k = 32'hc24b8b70;  6'd43: o_k = 32'hc76c51a3;
            6'd44: o_k = 32'hd192e819;  6'd45: o_k = 32'hd6990624;
            6'd46: o_k = 32'hf40e3585;  6'd47: o_k = 32'h106aa070;
            6'd48: o_k = 32'h19a4c116;  6'd49: o_k = 32'h1e376c08;
            6'd50: o_k = 32'h2748774c;  6'd51: o_k = 32'h34b0bcb5;
            6'd52: o_k = 32'h391c0cb3;  6'd53: o_k = 32'h4ed8aa4a;
            6'd54: o_k = 32'h5b9cca4f;  6'd55: o_k = 32'h682e6ff3;
            6'd56: o_k = 32'h748f82ee;  6'd57: o_k = 32'h78a5636f;
            6'd58: o_k = 32'h84c87814;  6'd59: o_k = 32'h8cc70208;
            6'd60: o_k = 32'h90befffa;  6'd61: o_k = 32'ha4506ceb;
            6'd62: o_k = 32'hbef9a3f7;  6'd63: o_k = 32'hc67178f2;
            default: o_k = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sha_round_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sha_round_engine
//  Purpose  : SHA-256 compression engine, one round per clock. Captures a
//             pre-expanded 64-word schedule, chaining value and nonce on an
//             en pulse, runs 64 rounds and reports Hin + working variables
//             with its nonce as a one-cycle valid pulse.
//  Ports    : clk, reset (async, active high)
//             en            start pulse; W/Hin/nonce sampled in that cycle
//             nonce [31:0]  job tag
//             W  [2047:0]   schedule, word i = W[i*32 +: 32]
//             Hin [255:0]   chaining value, H0 = Hin[255:224]
//             H_out [255:0] result, same word order as Hin
//             nonce_out     nonce of the reported job
//             valid         one-cycle result pulse
//             busy          engine is in RUN or FINAL
//             drop          one-cycle pulse: en rejected while running
//  Revision : 1.0  initial release
// ============================================================================
module sha_round_engine
    import sha_round_engine_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [WORD_W-1:0]          nonce,
    input  logic [ROUNDS*WORD_W-1:0]   W,
    input  logic [8*WORD_W-1:0]        Hin,
    output logic [8*WORD_W-1:0]        H_out,
    output logic [WORD_W-1:0]          nonce_out,
    output logic                       valid,
    output logic                       busy,
    output logic                       drop
);

    logic [1:0]                         r_state;
    logic [5:0]                         r_cnt;
    logic [WORD_W-1:0]                  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    // Element 7 holds H0 so the packed layout matches Hin directly.
    logic [7:0][WORD_W-1:0]             r_hsave;
    logic [ROUNDS-1:0][WORD_W-1:0]      r_wsave;
    logic [WORD_W-1:0]                  r_nonce_save;
    logic [8*WORD_W-1:0]                r_hout;
    logic [WORD_W-1:0]                  r_nonce_out;
    logic                               r_valid;
    logic                               r_drop;

    logic [WORD_W-1:0]                  w_k;
    logic [WORD_W-1:0]                  w_wi;
    logic [WORD_W-1:0]                  w_t1;
    logic [WORD_W-1:0]                  w_t2;
    logic                               w_accept;
    logic [7:0][WORD_W-1:0]             w_hin;

    sha_k_rom u_k_rom (
        .i_idx (r_cnt),
        .o_k   (w_k)
    );

    assign w_hin    = Hin;
    assign w_wi     = r_wsave[r_cnt];
    assign w_t1     = r_h + big_sig1(r_e) + ch(r_e, r_f, r_g) + w_k + w_wi;
    assign w_t2     = big_sig0(r_a) + maj(r_a, r_b, r_c);
    // FINAL accepts a new job in the same cycle it reports, giving 65-cycle throughput.
    assign w_accept = en && ((r_state == SRE_IDLE) || (r_state == SRE_FINAL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= SRE_IDLE;
            r_cnt        <= 6'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_d          <= '0;
            r_e          <= '0;
            r_f          <= '0;
            r_g          <= '0;
            r_h          <= '0;
            r_hsave      <= '0;
            r_wsave      <= '0;
            r_nonce_save <= '0;
            r_hout       <= '0;
            r_nonce_out  <= '0;
            r_valid      <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_valid <= (r_state == SRE_FINAL);
            r_drop  <= en && (r_state == SRE_RUN);

            if (r_state == SRE_FINAL) begin
                r_hout      <= {r_hsave[7] + r_a, r_hsave[6] + r_b,
                                r_hsave[5] + r_c, r_hsave[4] + r_d,
                                r_hsave[3] + r_e, r_hsave[2] + r_f,
                                r_hsave[1] + r_g, r_hsave[0] + r_h};
                r_nonce_out <= r_nonce_save;
            end

            if (w_accept) begin
                r_a          <= w_hin[7];
                r_b          <= w_hin[6];
                r_c          <= w_hin[5];
                r_d          <= w_hin[4];
                r_e          <= w_hin[3];
                r_f          <= w_hin[2];
                r_g          <= w_hin[1];
                r_h          <= w_hin[0];
                r_hsave      <= w_hin;
                r_wsave      <= W;
                r_nonce_save <= nonce;
                r_cnt        <= 6'd0;
                r_state      <= SRE_RUN;
            end else begin
                case (r_state)
                    SRE_RUN: begin
                        r_h   <= r_g;
                        r_g   <= r_f;
                        r_f   <= r_e;
                        r_e   <= r_d + w_t1;
                        r_d   <= r_c;
                        r_c   <= r_b;
                        r_b   <= r_a;
                        r_a   <= w_t1 + w_t2;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'(ROUNDS - 1)) begin
                            r_state <= SRE_FINAL;
                        end
                    end
                    SRE_FINAL: r_state <= SRE_IDLE;
                    default:   r_state <= SRE_IDLE;
                endcase
            end
        end
    end

    assign H_out     = r_hout;
    assign nonce_out = r_nonce_out;
    assign valid     = r_valid;
    assign drop      = r_drop;
    assign busy      = (r_state == SRE_RUN) || (r_state == SRE_FINAL);

endmodule
`default_nettype wire

// File: tb/tb_sha_round_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha_round_engine
//  Purpose  : Scoreboard bench for sha_round_engine using known SHA-256
//             digests ("abc", empty, two-block 448-bit message).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha_round_engine;

    localparam logic [255:0] IV  = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_MID   = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [31:0]   nonce = '0;
    logic [2047:0] W = '0;
    logic [255:0]  Hin = '0;
    logic [255:0]  H_out;
    logic [31:0]   nonce_out;
    logic          valid;
    logic          busy;
    logic          drop;

    sha_round_engine dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .nonce     (nonce),
        .W         (W),
        .Hin       (Hin),
        .H_out     (H_out),
        .nonce_out (nonce_out),
        .valid     (valid),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] h;
        logic [31:0]  n;
        int           c;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   valid_cnt = 0;
    int   drop_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message schedule expansion of one 512-bit block (word 0 in the MSBs).
    function automatic logic [2047:0] expand(input logic [511:0] blk);
        logic [31:0]   w [64];
        logic [2047:0] r;
        for (int j = 0; j < 16; j++) w[j] = blk[511 - 32*j -: 32];
        for (int j = 16; j < 64; j++) begin
            w[j] = (rotr(w[j-2], 17) ^ rotr(w[j-2], 19) ^ (w[j-2] >> 10)) + w[j-7]
                 + (rotr(w[j-15], 7) ^ rotr(w[j-15], 18) ^ (w[j-15] >> 3)) + w[j-16];
        end
        for (int j = 0; j < 64; j++) r[j*32 +: 32] = w[j];
        return r;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (drop) drop_cnt++;
            if (valid) begin
                exp_t e;
                valid_cnt++;
                check("drop_with_valid", 256'(drop), 256'(0));
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1 at cycle %0d expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("H_out", H_out, e.h);
                    check("nonce_out", 256'(nonce_out), 256'(e.n));
                    check("valid_cycle", 256'(cyc), 256'(e.c));
                end
            end
        end
    end

    // Drive a job in the next cycle; inputs are scrambled afterwards to show
    // they are only sampled at the accepting edge.
    task automatic issue(input logic [2047:0] w, input logic [255:0] h, input logic [31:0] n,
                         input logic [255:0] exp_h, input bit push);
        exp_t e;
        @(negedge clk);
        W = w;
        Hin = h;
        nonce = n;
        en = 1'b1;
        if (push) begin
            e.h = exp_h;
            e.n = n;
            e.c = cyc + 66;
            sbq.push_back(e);
        end
        @(negedge clk);
        en = 1'b0;
        W = ~w;
        Hin = ~h;
        nonce = ~n;
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (sbq.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int bad;
        // Reset state
        #1;
        check("rst_H_out", H_out, 256'h0);
        check("rst_nonce_out", 256'(nonce_out), 256'h0);
        check("rst_valid", 256'(valid), 256'h0);
        check("rst_busy", 256'(busy), 256'h0);
        check("rst_drop", 256'(drop), 256'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: "abc"
        issue(expand(B_ABC), IV, 32'hDEADBEEF, D_ABC, 1'b1);
        check("busy_run", 256'(busy), 256'h1);
        wait_drain(200);

        // 6: hold after job
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (H_out !== D_ABC || nonce_out !== 32'hDEADBEEF || valid !== 1'b0 ||
                drop !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("hold_stable", 256'(bad), 256'h0);

        // 2: empty message
        issue(expand(B_EMPTY), IV, 32'h00000001, D_EMPTY, 1'b1);
        wait_drain(200);

        // 3: two-block, second block accepted in FINAL of the first
        issue(expand(B_TWO1), IV, 32'h11111111, D_MID, 1'b1);
        repeat (63) @(negedge clk);
        issue(expand(B_TWO2), D_MID, 32'h22222222, D_TWO, 1'b1);
        wait_drain(300);

        // 4: en while running is dropped, job unaffected
        issue(expand(B_ABC), IV, 32'hCAFEF00D, D_ABC, 1'b1);
        repeat (10) @(negedge clk);
        en = 1'b1;
        W = {64{32'h5a5a5a5a}};
        Hin = {8{32'h12345678}};
        nonce = 32'h0BADBAD0;
        @(negedge clk);
        en = 1'b0;
        check("drop_pulse", 256'(drop), 256'h1);
        @(negedge clk);
        check("drop_one_cycle", 256'(drop), 256'h0);
        wait_drain(200);
        repeat (70) @(negedge clk);

        // 5: reset mid-job abandons it
        issue(expand(B_EMPTY), IV, 32'h77777777, 256'h0, 1'b0);
        repeat (30) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_H_out", H_out, 256'h0);
        check("midrst_nonce_out", 256'(nonce_out), 256'h0);
        check("midrst_busy", 256'(busy), 256'h0);
        check("midrst_valid", 256'(valid), 256'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        issue(expand(B_ABC), IV, 32'h55AA55AA, D_ABC, 1'b1);
        wait_drain(200);

        check("valid_count", 256'(valid_cnt), 256'd6);
        check("drop_count", 256'(drop_cnt), 256'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
